i2s_transmitter: RTL
====================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per channel; one frame = 4*SAMPLE_WIDTH clocks (64 at default).
REQ-002 SHALL have port clock  input  1  system audio clock (2.048 MHz nominal).
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  high = run serializer; low = idle.
REQ-005 SHALL have port sample_l  input  SAMPLE_WIDTH  signed left sample.
REQ-006 SHALL have port sample_r  input  SAMPLE_WIDTH  signed right sample.
REQ-007 SHALL have port sample_valid  input  1  one-cycle strobe; captures sample_l/sample_r.
REQ-008 SHALL have port i2s_bclk  output  1  bit clock, clock/2.
REQ-009 SHALL have port i2s_lrclk  output  1  word select: 0 = left, 1 = right.
REQ-010 SHALL have port i2s_data  output  1  serial data, MSB first.
REQ-011 SHALL have port underrun  output  1  one-cycle pulse: frame loaded with no new sample pending.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse: sample_valid while a sample is already pending.

Function
REQ-013 SHALL keep a phase counter 0..4*SAMPLE_WIDTH-1 that increments every clock while enable=1 and wraps to 0.
REQ-014 SHALL drive i2s_bclk = phase[0]: low on even phases, high on odd; data changes only on entry to even phases.
REQ-015 SHALL define slot k = phase/2 (0..2*SAMPLE_WIDTH-1); i2s_lrclk = 0 for k < SAMPLE_WIDTH, 1 otherwise.
REQ-016 SHALL emit standard I2S, one-slot delay: slot 0 = previous frame right LSB; slots 1..SAMPLE_WIDTH = left MSB..LSB; slots SAMPLE_WIDTH+1..2*SAMPLE_WIDTH-1 = right MSB..bit1.
REQ-017 SHALL capture sample_l/sample_r into a holding register and set pending when sample_valid=1.
REQ-018 SHALL load the frame shift register from holding at phase 2 (start of slot 1) and clear pending.
REQ-019 SHALL pulse underrun for one cycle when the load at phase 2 finds pending=0.
REQ-020 SHALL, on sample_valid while pending=1, overwrite holding with the newer sample and pulse overrun for one cycle.
REQ-021 SHALL, when sample_valid coincides with the phase-2 load, load the incoming sample directly, leave pending=0 and pulse neither flag.
REQ-022 SHALL, when enable=0, force phase to 0 and i2s_bclk, i2s_lrclk, i2s_data to 0; holding and pending keep updating from sample_valid.
REQ-023 SHALL register all outputs (no combinational path from inputs to i2s_* pins).

Reset
REQ-024 SHALL, while reset_n=0, clear phase, holding, shift register and pending to 0 and drive all outputs to 0.
REQ-025 SHALL restart at phase 0 on the first clock after reset_n deasserts; a reset mid-frame abandons the frame with no flag pulses.

Configuration
REQ-026 SHALL honour macro I2S_TX_UNDERRUN_MUTE_EN: when defined, an underrun loads all-zero data for both channels.
REQ-027 SHALL, without I2S_TX_UNDERRUN_MUTE_EN, repeat the last holding contents on underrun; the underrun pulse occurs in both builds.

Structure
REQ-028 SHALL take SAMPLE_WIDTH default, FRAME_CLOCKS (=64) and the load phase constant (=2) from shared package dsp_audio_pkg, also used by the DSP output stage.
REQ-029 SHALL be a single module with no sub-modules; phase counter, holding register and shift register are inline.

Verification
REQ-030 SHALL check: reset, enable=1, sample_valid once with L=16'hA5C3, R=16'h0F0F before phase 2 -> slots 1..16 serialize A5C3 MSB-first with lrclk=0, slots 17..31 plus next slot 0 serialize 0F0F, no flags.
REQ-031 SHALL check: no sample_valid for a frame after valid L=16'h1234 -> underrun pulse at phase 2; frame data 0000/0000 with MUTE_EN, 1234/R repeated without.
REQ-032 SHALL check: two sample_valid strobes (L=16'h1111, then 16'h2222) before one load -> one overrun pulse; frame carries 2222.
REQ-033 SHALL check: sample_valid exactly at phase 2 with L=16'h8001 -> 8001 transmitted this frame, no underrun, no overrun.
REQ-034 SHALL check: reset_n pulled low at phase 37 -> all outputs 0 immediately; after release, lrclk/bclk restart from phase 0, no flags.
REQ-035 SHALL check: enable low for 10 cycles mid-frame -> pins held 0, phase 0 on re-enable; bclk period 2 clocks, lrclk period 64 clocks thereafter.

Source files
------------

// File: rtl/dsp_audio_pkg.sv
// Audio-path constants shared by the DSP output stage and the I2S transmitter.
package dsp_audio_pkg;

  localparam int unsigned SAMPLE_WIDTH_DEF = 16;
  localparam int unsigned FRAME_CLOCKS     = 4 * SAMPLE_WIDTH_DEF;
  localparam int unsigned LOAD_PHASE       = 2;

  function automatic int unsigned frame_clocks(input int unsigned width);
    return 4 * width;
  endfunction

endpackage

// File: rtl/i2s_transmitter.sv
// Standard I2S serializer: one-slot-delayed data, bclk = clock/2, 4*SAMPLE_WIDTH clocks per frame.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating the held sample on underrun.
module i2s_transmitter
  import dsp_audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_l,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                           sample_valid,
  output logic                           i2s_bclk,
  output logic                           i2s_lrclk,
  output logic                           i2s_data,
  output logic                           underrun,
  output logic                           overrun
);

  localparam int unsigned FRAME = frame_clocks(SAMPLE_WIDTH);
  localparam int unsigned PW    = $clog2(FRAME);
  localparam int unsigned FW    = 2 * SAMPLE_WIDTH;

  localparam logic [PW-1:0] LAST_PHASE  = PW'(FRAME - 1);
  localparam logic [PW-1:0] LOAD_AT     = PW'(LOAD_PHASE);
  localparam logic [PW-1:0] RIGHT_START = PW'(FW);

  logic [PW-1:0] phase, phase_next;
  logic [FW-1:0] holding, holding_next;
  logic [FW-1:0] shift_reg, shift_next;
  logic [FW-1:0] incoming, refill;
  logic          pending, pending_next;
  logic          underrun_next, overrun_next;
  logic          load, advance;

  assign incoming = {sample_l, sample_r};

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  assign refill = '0;
`else
  assign refill = holding;
`endif

  always_comb begin
    phase_next = '0;
    if (enable) phase_next = (phase == LAST_PHASE) ? '0 : phase + PW'(1);
  end

  // The load edge is the one entering slot 1; every other even-phase entry shifts one bit.
  assign load    = enable && (phase_next == LOAD_AT);
  assign advance = enable && !phase_next[0] && !load;

  always_comb begin
    shift_next    = shift_reg;
    holding_next  = holding;
    pending_next  = pending;
    underrun_next = 1'b0;
    overrun_next  = 1'b0;
    if (load) begin
      pending_next = 1'b0;
      if (sample_valid) begin
        holding_next = incoming;
        shift_next   = incoming;
      end else if (pending) begin
        shift_next = holding;
      end else begin
        shift_next    = refill;
        underrun_next = 1'b1;
      end
    end else begin
      if (sample_valid) begin
        holding_next = incoming;
        pending_next = 1'b1;
        overrun_next = pending;
      end
      // Rotation brings the right LSB back to the MSB position for slot 0.
      if (advance) shift_next = {shift_reg[FW-2:0], shift_reg[FW-1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= '0;
      holding   <= '0;
      shift_reg <= '0;
      pending   <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_data  <= 1'b0;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      phase     <= phase_next;
      holding   <= holding_next;
      shift_reg <= shift_next;
      pending   <= pending_next;
      underrun  <= underrun_next;
      overrun   <= overrun_next;
      i2s_bclk  <= phase_next[0];
      i2s_lrclk <= (phase_next >= RIGHT_START);
      if (!enable)              i2s_data <= 1'b0;
      else if (load || advance) i2s_data <= shift_next[FW-1];
    end
  end

endmodule
